// File: rtl/mux_scan_reg_if.sv
// mux_scan_reg_if
//   Bundles the channel bank inputs, the control inputs and the output
//   sample stream of mux_scan_reg.
//   Modports:
//     master : the mux itself (drives the output stream, reads the channels).
//     slave  : the surrounding system (drives channels/controls, consumes samples).
//   Signals:
//     mode      1 = auto-scan, 0 = manual
//     addr      manual channel select / scan start channel
//     chEnable  scan mask, one bit per channel
//     inData    channel k = inData[k*DATA_W +: DATA_W]
//     outReady  consumer ready
//     outData   registered selected sample
//     outAddr   channel index of outData
//     outValid  outData/outAddr/addrErr hold a sample
//     addrErr   manual addr was out of range (outData forced to 0)
//     scanWrap  one-cycle pulse when the scan pointer steps to a lower-or-equal index
interface mux_scan_reg_if #(
  parameter int CH_NUM = 8,
  parameter int DATA_W = 8
);
  localparam int SEL_W = $clog2(CH_NUM);

  logic                     mode;
  logic [SEL_W-1:0]         addr;
  logic [CH_NUM-1:0]        chEnable;
  logic [CH_NUM*DATA_W-1:0] inData;
  logic                     outReady;
  logic [DATA_W-1:0]        outData;
  logic [SEL_W-1:0]         outAddr;
  logic                     outValid;
  logic                     addrErr;
  logic                     scanWrap;

  modport master (
    input  mode, addr, chEnable, inData, outReady,
    output outData, outAddr, outValid, addrErr, scanWrap
  );

  modport slave (
    output mode, addr, chEnable, inData, outReady,
    input  outData, outAddr, outValid, addrErr, scanWrap
  );
endinterface

// File: rtl/mux_scan_reg.sv
// mux_scan_reg
//   Registered CH_NUM x DATA_W multiplexer between a bank of channels and a
//   single downstream consumer. Manual mode samples the channel named by addr
//   every free cycle; auto-scan mode visits the enabled channels round-robin,
//   spending DWELL cycles per slot.
//   Ports:
//     clk       rising-edge clock
//     rst       synchronous active-high reset, overrides everything
//     bus       mux_scan_reg_if.master (channels, controls, output stream)
//     dbgState  1 = SCAN, 0 = MANUAL
//     dbgPtr    current scan pointer
//
//   Handshake: a sample is transferred on every rising edge where
//   outValid && outReady. While outValid=1 and outReady=0 the output slot is
//   occupied and outData/outAddr/outValid/addrErr hold stable; the slot is
//   free when !outValid || outReady, and only then may a new sample (or
//   outValid<=0) be loaded.
module mux_scan_reg #(
  parameter  int CH_NUM = 8,
  parameter  int DATA_W = 8,
  parameter  int DWELL  = 4,
  localparam int SEL_W  = $clog2(CH_NUM)
) (
  input  logic             clk,
  input  logic             rst,
  mux_scan_reg_if.master   bus,
  output logic             dbgState,
  output logic [SEL_W-1:0] dbgPtr
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } state_t;

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [CNT_W-1:0] dwellCnt;

  logic             slotFree;
  logic             addrBad;
  logic             dwellDone;
  logic [DATA_W-1:0] manData;
  logic [DATA_W-1:0] scanData;
  logic             ptrEn;
  logic [SEL_W-1:0] hiIdx;
  logic [SEL_W-1:0] loIdx;
  logic             hiFound;
  logic             loFound;
  logic [SEL_W-1:0] nextPtr;
  logic             wrapNext;

  assign slotFree  = !bus.outValid || bus.outReady;
  // Widened by one bit so CH_NUM itself (e.g. 8 with SEL_W=3) is representable.
  assign addrBad   = {1'b0, bus.addr} >= (SEL_W + 1)'(CH_NUM);
  assign dwellDone = (dwellCnt == CNT_W'(DWELL - 1));

  // Channel selection by comparison loop so that out-of-range indices
  // (possible when CH_NUM is not a power of two) simply select nothing.
  always_comb begin
    manData  = '0;
    scanData = '0;
    ptrEn    = 1'b0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (bus.addr == SEL_W'(k)) manData = bus.inData[k*DATA_W +: DATA_W];
      if (ptr == SEL_W'(k)) begin
        scanData = bus.inData[k*DATA_W +: DATA_W];
        ptrEn    = bus.chEnable[k];
      end
    end
  end

  // Next enabled channel after ptr: lowest enabled index above ptr, else the
  // lowest enabled index at or below ptr (a wrap), else ptr itself.
  // Scanning downwards leaves the lowest match in each candidate.
  always_comb begin
    hiIdx   = '0;
    loIdx   = '0;
    hiFound = 1'b0;
    loFound = 1'b0;
    for (int k = CH_NUM - 1; k >= 0; k--) begin
      if (bus.chEnable[k]) begin
        if (SEL_W'(k) > ptr) begin
          hiIdx   = SEL_W'(k);
          hiFound = 1'b1;
        end else begin
          loIdx   = SEL_W'(k);
          loFound = 1'b1;
        end
      end
    end
    nextPtr  = hiFound ? hiIdx : (loFound ? loIdx : ptr);
    wrapNext = !hiFound && loFound;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= MANUAL;
      ptr          <= '0;
      dwellCnt     <= '0;
      bus.outData  <= '0;
      bus.outAddr  <= '0;
      bus.outValid <= 1'b0;
      bus.addrErr  <= 1'b0;
      bus.scanWrap <= 1'b0;
    end else begin
      bus.scanWrap <= 1'b0;
      case (state)
        MANUAL: begin
          // The entry cycle still behaves as manual; scanning starts next cycle.
          if (slotFree) begin
            bus.outValid <= 1'b1;
            bus.outAddr  <= bus.addr;
            bus.outData  <= addrBad ? '0 : manData;
            bus.addrErr  <= addrBad;
          end
          if (bus.mode) begin
            state    <= SCAN;
            ptr      <= addrBad ? '0 : bus.addr;
            dwellCnt <= '0;
          end
        end
        SCAN: begin
          // Leaving scan takes effect next cycle; a sample due now is still taken.
          if (!bus.mode) state <= MANUAL;
          if (!dwellDone) begin
            dwellCnt <= dwellCnt + CNT_W'(1);
            if (slotFree) bus.outValid <= 1'b0;
          end else if (slotFree) begin
            if (ptrEn) begin
              bus.outValid <= 1'b1;
              bus.outAddr  <= ptr;
              bus.outData  <= scanData;
              bus.addrErr  <= 1'b0;
            end else begin
              bus.outValid <= 1'b0;
            end
            ptr          <= nextPtr;
            dwellCnt     <= '0;
            bus.scanWrap <= wrapNext;
          end
          // Otherwise the counter stays at DWELL-1 until the consumer frees
          // the slot, so a stall slows the scan instead of dropping a sample.
        end
      endcase
    end
  end

  assign dbgState = (state == SCAN);
  assign dbgPtr   = ptr;

endmodule
